alu_initiator: RTL and testbench

ALU_INITIATOR -- requirements
Module: alu_initiator

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 57 +++++
 rtl/alu_initiator.sv | 154 +++++++++++++++
 tb/tb_alu_initiator.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the ALU initiator and its command FIFO.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_CMP = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9
  } alu_op_e;

  localparam logic [3:0] OP_MAX = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Opcodes past OP_MAX and divide-by-zero are answered with an error, never issued.
  function automatic logic op_is_legal(input logic [3:0] op, input logic b_is_zero);
    return (op <= OP_MAX) && !((op == OP_DIV) && b_is_zero);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU initiator; Depth must be a power of two (>= 2) so the
// pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int DataW = 12,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             push_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [DataW-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_initiator.sv
// Sequences one command at a time into a registered ALU and returns its result.
// Optional command FIFO enabled by defining ALU_INITIATOR_FIFO_EN.
module alu_initiator
  import alu_pkg::*;
#(
  parameter int Width     = 4,
  parameter int FifoDepth = 4
) (
  input  logic               clk,
  input  logic               arst,
  // Both channels: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready and its payload holds until the transfer.
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [Width-1:0]   cmd_a,
  input  logic [Width-1:0]   cmd_b,
  output logic [Width-1:0]   alu_a,
  output logic [Width-1:0]   alu_b,
  output logic [3:0]         alu_op,
  output logic               alu_enable,
  input  logic [2*Width-1:0] alu_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*Width-1:0] rsp_data,
  output logic [3:0]         rsp_op,
  output logic               rsp_err,
  output state_e             dbg_state
);

  state_e             state_q, state_d;
  logic [Width-1:0]   alu_a_q, alu_a_d;
  logic [Width-1:0]   alu_b_q, alu_b_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [2*Width-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_op_q, rsp_op_d;
  logic               rsp_err_q, rsp_err_d;

  // Command source seen by IDLE: either the FIFO head or the port itself.
  logic               src_valid;
  logic [3:0]         src_op;
  logic [Width-1:0]   src_a, src_b;

`ifdef ALU_INITIATOR_FIFO_EN
  localparam int CmdW = 4 + 2*Width;

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CmdW-1:0] fifo_rdata;

  assign cmd_ready = arst & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
  assign src_valid = ~fifo_empty;
  assign {src_op, src_a, src_b} = fifo_rdata;

  alu_cmd_fifo #(
    .DataW (CmdW),
    .Depth (FifoDepth)
  ) u_cmd_fifo (
    .clk     (clk),
    .arst    (arst),
    .push_i  (fifo_push),
    .wdata_i ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
`else
  logic unused_fifo_depth;
  assign unused_fifo_depth = (FifoDepth > 0);

  // Gated by arst so the port reads 0 while reset is held.
  assign cmd_ready = arst & (state_q == IDLE);
  assign src_valid = cmd_valid;
  assign src_op    = cmd_op;
  assign src_a     = cmd_a;
  assign src_b     = cmd_b;
`endif

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_data_d = rsp_data_q;
    rsp_op_d   = rsp_op_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (src_valid) begin
          alu_op_d = src_op;
          alu_a_d  = src_a;
          alu_b_d  = src_b;
          if (op_is_legal(src_op, src_b == '0)) begin
            state_d = ISSUE;
          end else begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_op_d   = src_op;
            state_d    = RESP;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      // The ALU registered its result on the edge that ended ISSUE.
      WAIT: begin
        rsp_data_d = alu_res;
        rsp_err_d  = 1'b0;
        rsp_op_d   = alu_op_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_enable = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_initiator.sv
// Directed bench for alu_initiator (Width=4) with a one-cycle registered ALU model;
// covers the FIFO build too when ALU_INITIATOR_FIFO_EN is defined.
module tb_alu_initiator;
  import alu_pkg::*;

  localparam int W  = 4;
  localparam int RW = 1 + 4 + 2*W;
`ifdef ALU_INITIATOR_FIFO_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic           clk = 1'b0;
  logic           arst = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = '0;
  logic [W-1:0]   cmd_a = '0, cmd_b = '0;
  logic [W-1:0]   alu_a, alu_b;
  logic [3:0]     alu_op;
  logic           alu_enable;
  logic [2*W-1:0] alu_res = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_data;
  logic [3:0]     rsp_op;
  logic           rsp_err;
  state_e         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct packed {
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           err;
  } vec_t;

  alu_initiator #(.Width(W), .FifoDepth(4)) dut (
    .clk        (clk),
    .arst       (arst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_enable (alu_enable),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Registered ALU; compare answers {a>b, a==b, a<b}.
  function automatic logic [2*W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [2*W-1:0] xa, xb;
    xa = {{W{1'b0}}, a};
    xb = {{W{1'b0}}, b};
    case (op)
      4'd0: return xa + xb;
      4'd1: return xa - xb;
      4'd2: return xa * xb;
      4'd3: return (b == '0) ? '0 : xa / xb;
      4'd4: return xa & xb;
      4'd5: return xa | xb;
      4'd6: return xa ^ xb;
      4'd7: return {{(2*W-3){1'b0}}, a > b, a == b, a < b};
      4'd8: return xa << b;
      4'd9: return xa >> b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_enable) begin
      en_cnt  <= en_cnt + 1;
      alu_res <= alu_model(alu_op, alu_a, alu_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_accept", 32'(waited < 50), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    int waited = 0;
    logic [RW-1:0] exp;
    rsp_ready = 1'b1;
    while (!rsp_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_rsp_valid"}, 32'(waited < 50), 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, 32'(rsp_data), 32'(exp[2*W-1:0]));
    check({tag, "_op"},   32'(rsp_op),   32'(exp[2*W+3:2*W]));
    check({tag, "_err"},  32'(rsp_err),  32'(exp[RW-1]));
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  vec_t vecs [15];

  initial begin
    int base, n, en_at, hits;
    vecs = '{
      '{4'd2,  4'd15, 4'd15, 8'd225, 1'b0},
      '{4'd1,  4'd9,  4'd4,  8'd5,   1'b0},
      '{4'd1,  4'd3,  4'd5,  8'd254, 1'b0},
      '{4'd3,  4'd14, 4'd3,  8'd4,   1'b0},
      '{4'd3,  4'd14, 4'd1,  8'd14,  1'b0},
      '{4'd4,  4'd12, 4'd10, 8'd8,   1'b0},
      '{4'd5,  4'd12, 4'd3,  8'd15,  1'b0},
      '{4'd6,  4'd10, 4'd6,  8'd12,  1'b0},
      '{4'd7,  4'd5,  4'd9,  8'd1,   1'b0},
      '{4'd8,  4'd15, 4'd3,  8'd120, 1'b0},
      '{4'd9,  4'd12, 4'd2,  8'd3,   1'b0},
      '{4'd3,  4'd7,  4'd0,  8'd0,   1'b1},
      '{4'd10, 4'd1,  4'd1,  8'd0,   1'b1},
      '{4'd12, 4'd4,  4'd4,  8'd0,   1'b1},
      '{4'd15, 4'd15, 4'd15, 8'd0,   1'b1}
    };

    // Reset values while arst is held low.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
    check("rst_alu_enable", 32'(alu_enable), 32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_err",    32'(rsp_err),    32'd0);
    check("rst_rsp_data",   32'(rsp_data),   32'd0);
    check("rst_rsp_op",     32'(rsp_op),     32'd0);
    check("rst_alu_a",      32'(alu_a),      32'd0);
    check("rst_alu_b",      32'(alu_b),      32'd0);
    check("rst_alu_op",     32'(alu_op),     32'd0);
    check("rst_state",      32'(dbg_state),  32'(IDLE));
    arst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Add 3+5 with cycle-accurate latency and a single issue strobe.
    base  = en_cnt;
    en_at = 0;
    n     = 0;
    cmd_valid = 1'b1;
    cmd_op = 4'd0;
    cmd_a  = 4'd3;
    cmd_b  = 4'd5;
    do begin
      @(negedge clk);
      n++;
      cmd_valid = 1'b0;
      if (alu_enable) en_at = n;
    end while (!rsp_valid && n < 20);
    check("add_latency",     32'(n),             32'(LAT));
    check("add_issue_cycle", 32'(en_at),         32'(LAT - 2));
    check("add_en_pulses",   32'(en_cnt - base), 32'd1);
    check("add_alu_a_hold",  32'(alu_a),         32'd3);
    check("add_alu_b_hold",  32'(alu_b),         32'd5);
    check("add_alu_op_hold", 32'(alu_op),        32'd0);
    exp_q.push_back({1'b0, 4'd0, 8'd8});
    get_rsp("add");

    // Directed vector table, including illegal opcodes and divide by zero.
    foreach (vecs[i]) begin
      base = en_cnt;
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      exp_q.push_back({vecs[i].err, vecs[i].op, vecs[i].res});
      get_rsp($sformatf("vec%0d", i));
      check($sformatf("vec%0d_en", i), 32'(en_cnt - base), 32'(!vecs[i].err));
    end

`ifndef ALU_INITIATOR_FIFO_EN
    // Response backpressure: payload holds and no second command is taken.
    base = en_cnt;
    send_cmd(4'd2, 4'd6, 4'd7);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op = 4'd0;
    cmd_a  = 4'd1;
    cmd_b  = 4'd2;
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data",  32'(rsp_data),  32'd42);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    check("bp_en_pulses", 32'(en_cnt - base), 32'd1);
    exp_q.push_back({1'b0, 4'd2, 8'd42});
    get_rsp("bp_first");
    send_cmd(4'd0, 4'd1, 4'd2);
    exp_q.push_back({1'b0, 4'd0, 8'd3});
    get_rsp("bp_second");
    check("bp_total_en", 32'(en_cnt - base), 32'd2);
`else
    // Six back-to-back commands against a stalled response channel.
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 4'd0;
      cmd_a  = 4'(i);
      cmd_b  = 4'd1;
      exp_q.push_back({1'b0, 4'd0, 8'(i + 1)});
      check($sformatf("fifo_cmd_ready%0d", i), 32'(cmd_ready), 32'(i < 5));
      if (i < 5) @(negedge clk);
    end
    rsp_ready = 1'b1;
    hits = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      logic took;
      logic [RW-1:0] exp;
      took = cmd_valid & cmd_ready;
      if (rsp_valid) begin
        exp = exp_q.pop_front();
        check("fifo_rsp_data", 32'(rsp_data), 32'(exp[2*W-1:0]));
        check("fifo_rsp_err",  32'(rsp_err),  32'd0);
        hits++;
      end
      @(negedge clk);
      n++;
      if (took) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    check("fifo_rsp_count", 32'(hits), 32'd6);
`endif

    // Reset while the command sits in WAIT.
    send_cmd(4'd0, 4'd2, 4'd2);
    n = 0;
    while (dbg_state != WAIT && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_in_wait", 32'(dbg_state), 32'(WAIT));
    arst = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_state",     32'(dbg_state), 32'(IDLE));
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    rsp_ready = 1'b1;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    rsp_ready = 1'b0;
    check("mid_rst_no_stale", 32'(hits), 32'd0);
    check("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
    send_cmd(4'd0, 4'd7, 4'd8);
    exp_q.push_back({1'b0, 4'd0, 8'd15});
    get_rsp("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
